dpram_stream_reader: RTL
========================

Name: dpram_stream_reader

Overview:
- Downstream read-side stage for the simple dual-port RAM.
- Accepts a burst command (base address, word count) and drives the RAM read address port.
- Absorbs the RAM's 1-cycle registered read latency and presents the words as a valid/ready stream with last marker and no bubbles under continuous ready.
- Sits between the RAM and any streaming consumer, such as a DMA or output FIFO.

Parameters:
- WIDTH, 32: data word width; must match the RAM WIDTH.
- DEPTH, 10: RAM address bits used; the address wraps modulo 2^DEPTH.
- FIFO_WORDS, 2: internal skid/elastic entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  command strobe; accepted only when busy=0
- base_addr  in  32  first word address of burst
- count  in  32  number of words to read
- busy  out  1  high from accepted start until the last beat is transferred
- done  out  1  one-cycle pulse after the last beat is transferred, or after a count=0 command
- ram_raddress  out  32  to RAM raddress
- ram_dout  in  WIDTH  from RAM dout, valid one cycle after the address is sampled
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_data  out  WIDTH  stream data
- m_last  out  1  high with the final beat of the burst

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low.
- Reset values (reset=0 at a clk edge):
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, ram_raddress=0.
  - FIFO empty, all counters 0, FSM in IDLE.
- Reset mid-burst: the burst is dropped. No done pulse. The RAM word in flight is discarded.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 with count>0: latch base_addr into the address register and count into the issue and beat counters; go to ISSUE; busy=1 from the next cycle.
  - start=1 with count=0: done=1 for one cycle next cycle; stay in IDLE; busy stays 0.
- ISSUE:
  - Each cycle, issue a read when issues remain and (fifo_occ + inflight - pop) < 2.
  - pop = m_valid & m_ready in the current cycle.
  - inflight = read issued in the previous cycle.
  - On issue: ram_raddress holds the current address. Next cycle, address+1 (32-bit; the RAM uses the low DEPTH bits, so the address wraps naturally) and issue counter-1.
  - When the last read has issued, go to DRAIN.
- DRAIN:
  - Wait until the beat counter reaches 0, i.e. the last pop.
  - Then go to IDLE, pulse done for one cycle, and drop busy in that same cycle.
- Latency:
  - Start sampled at edge E0.
  - ram_raddress=base during the cycle after E0; the RAM samples it at E1.
  - The data is captured into the FIFO at E2, so m_valid=1 after E2.
  - The first beat is therefore visible 2 edges after start.
- Throughput: with m_ready held at 1, one beat per cycle, no bubbles.
- Stream rules:
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer.
  - m_last=1 exactly on the beat where the beat counter equals 1.
- Backpressure: with m_ready=0 for any length, there are at most 2 FIFO entries plus 0 in flight. No RAM word is lost or duplicated.
- Simultaneous FIFO push and pop: occupancy unchanged, order preserved.
- start while busy=1: ignored, with no effect on state.
- Back-to-back bursts: start is accepted in the same cycle the done pulse is high, since busy=0 then.
- count width: full 32-bit. Bursts longer than 2^DEPTH re-read wrapped addresses.

Optional Feature:
- Macro: DPRAM_STREAM_READER_ABORT_EN.
- When defined, adds input port abort (1 bit).
- abort=1 while busy=1:
  - Next cycle: stop issuing, flush the FIFO, discard the in-flight word, force m_valid=0, go to IDLE.
  - busy=0 and done pulses once in that cycle.
- abort while IDLE: ignored. Abort takes priority over a same-cycle pop.
- When not defined: no abort port, and the logic is absent.

Test Plan:
- RAM preloaded mem[i]=i+0x100. start, base=4, count=4, m_ready=1 → beats 0x104..0x107 on 4 consecutive cycles; first m_valid 2 edges after start; m_last on 0x107; done 1 cycle after the last beat.
- base=0x3FE, count=4, DEPTH=10 → data mem[0x3FE], mem[0x3FF], mem[0], mem[1]; ram_raddress shows 0x3FE..0x401.
- count=8 with m_ready toggled 1,0,0,1,0,1... → exactly 8 beats, in order, none dropped or duplicated; m_data stable while stalled.
- count=0 → done pulse next cycle; m_valid never rises; busy stays 0.
- start pulsed again mid-burst with different base → ignored; the original burst completes unchanged.
- reset=0 asserted after 2 of 6 beats → all outputs 0 next cycle; no done; a new start afterwards works normally.
- ABORT_EN: abort after beat 2 of count=6 → m_valid=0 next cycle; done once; no further ram reads.

Source files
------------

// File: rtl/dpram_stream_reader.sv
// Burst reader for the simple dual-port RAM: issues read addresses, absorbs the
// 1-cycle RAM latency and streams words out. Optional abort port: DPRAM_STREAM_READER_ABORT_EN.
module dpram_stream_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 10,
  parameter int FIFO_WORDS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DPRAM_STREAM_READER_ABORT_EN
  input  logic             abort,
`endif
  input  logic [31:0]      base_addr,
  input  logic [31:0]      count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      ram_raddress,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  if (FIFO_WORDS != 2 || DEPTH < 1 || DEPTH > 32) begin : g_bad_params
    $error("dpram_stream_reader: FIFO_WORDS must be 2 and DEPTH in 1..32");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      issue_cnt_q, issue_cnt_d;
  logic [31:0]      beat_cnt_q, beat_cnt_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [FIFO_WORDS];
  logic [WIDTH-1:0] mem_d [FIFO_WORDS];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       occ_q, occ_d;

  logic             pop;
  logic             push;
  logic             issue;
  logic             flush;
  logic [2:0]       pending;

`ifdef DPRAM_STREAM_READER_ABORT_EN
  assign flush = abort && (state_q != S_IDLE);
`else
  assign flush = 1'b0;
`endif

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign ram_raddress = addr_q;
  assign m_valid      = (occ_q != 2'd0);
  assign m_data       = mem_q[rd_ptr_q];
  assign m_last       = m_valid && (beat_cnt_q == 32'd1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    pop  = m_valid && m_ready;
    push = inflight_q;
    // Words already owed to the FIFO after this cycle's pop; never exceed its two slots.
    pending = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue   = (state_q == S_ISSUE) && (issue_cnt_q != 32'd0) &&
              (pending < 3'(FIFO_WORDS)) && !flush;
    inflight_d = issue;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != 32'd0) begin
            addr_d      = base_addr;
            issue_cnt_d = count;
            beat_cnt_d  = count;
            state_d     = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + 32'd1;
          issue_cnt_d = issue_cnt_q - 32'd1;
          if (issue_cnt_q == 32'd1) state_d = S_DRAIN;
        end
      end
      default: ;
    endcase

    if (pop) begin
      beat_cnt_d = beat_cnt_q - 32'd1;
      rd_ptr_d   = ~rd_ptr_q;
      if (beat_cnt_q == 32'd1) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = ram_dout;
      wr_ptr_d        = ~wr_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};

    // Abort wins over everything in flight, including a same-cycle pop.
    if (flush) begin
      state_d     = S_IDLE;
      done_d      = 1'b1;
      inflight_d  = 1'b0;
      occ_d       = 2'd0;
      rd_ptr_d    = 1'b0;
      wr_ptr_d    = 1'b0;
      issue_cnt_d = 32'd0;
      beat_cnt_d  = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= '0;
      // NOTE: the two skid entries are reset because m_data must read 0 after reset.
      for (int i = 0; i < FIFO_WORDS; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      mem_q       <= mem_d;
    end
  end

endmodule
